// File: rtl/ext_arbiter_pkg.sv
// Shared widths and encodings for the two-requester immediate-extender arbiter.
package ext_arbiter_pkg;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;

    typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_e;
    typedef enum logic {ZERO = 1'b0, SIGN = 1'b1} ext_mode_e;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} arb_state_e;

endpackage

// File: rtl/ext_16_32.sv
// 16-to-32 immediate extender: zero- or sign-fills the upper half.
module ext_16_32
    import ext_arbiter_pkg::*;
(
    input  logic [IMM_W-1:0]  i_imm,
    input  ext_mode_e         i_mode,
    output logic [DATA_W-1:0] o_data
);

    logic w_fill;

    assign w_fill = (i_mode == SIGN) ? i_imm[IMM_W-1] : 1'b0;
    assign o_data = {{(DATA_W-IMM_W){w_fill}}, i_imm};

endmodule

// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one registered 16-to-32 extender between two requesters,
// presenting the result on a valid/ready port tagged with the owning requester.
module ext_arbiter
    import ext_arbiter_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_sign,
    input  logic [IMM_W-1:0]  req0_imm,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_sign,
    input  logic [IMM_W-1:0]  req1_imm,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready,
    output logic              busy
);

    arb_state_e       r_state;
    arb_state_e       w_nextState;
    req_id_e          r_lastGrant;
    req_id_e          r_id;
    ext_mode_e        r_mode;
    logic [IMM_W-1:0] r_imm;

    logic             w_canAccept;
    logic             w_grantValid;
    req_id_e          w_grantId;
    logic             w_accept;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantId    = REQ0;
        if (req0_valid && req1_valid) begin
            w_grantValid = 1'b1;
            w_grantId    = (r_lastGrant == REQ0) ? REQ1 : REQ0;
        end else if (req0_valid) begin
            w_grantValid = 1'b1;
            w_grantId    = REQ0;
        end else if (req1_valid) begin
            w_grantValid = 1'b1;
            w_grantId    = REQ1;
        end
    end

    assign w_canAccept = !rst && ((r_state == EMPTY) || rsp_ready);
    assign w_accept    = w_canAccept && w_grantValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_nextState = FULL;
            FULL:  if (rsp_ready && !w_accept) w_nextState = EMPTY;
            default: w_nextState = EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid  = (r_state == FULL);
        busy       = (r_state == FULL);
        req0_ready = w_accept && (w_grantId == REQ0);
        req1_ready = w_accept && (w_grantId == REQ1);
    end

    // The operand register keeps its value after consumption; only a new accept replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imm       <= '0;
            r_mode      <= ZERO;
            r_id        <= REQ0;
            r_lastGrant <= req_id_e'(~RR_INIT);
        end else if (w_accept) begin
            r_imm       <= (w_grantId == REQ0) ? req0_imm : req1_imm;
            r_mode      <= (w_grantId == REQ0) ? ext_mode_e'(req0_sign) : ext_mode_e'(req1_sign);
            r_id        <= w_grantId;
            r_lastGrant <= w_grantId;
        end
    end

    ext_16_32 u_ext (
        .i_imm  (r_imm),
        .i_mode (r_mode),
        .o_data (rsp_data)
    );

    assign rsp_id = r_id;

endmodule

// File: tb/tb_ext_arbiter.sv
// Self-checking bench for ext_arbiter: directed scenarios followed by randomized
// traffic, all compared against a transaction-level reference model.
module tb_ext_arbiter;

    localparam bit RR = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_sign, req0_ready;
    logic [15:0] req0_imm;
    logic        req1_valid, req1_sign, req1_ready;
    logic [15:0] req1_imm;
    logic        rsp_valid, rsp_id, rsp_ready, busy;
    logic [31:0] rsp_data;

    int testCount = 0;
    int failCount = 0;

    // Reference model: the result register as seen by the consumer.
    logic        mValid, mId, mLast;
    logic [31:0] mData;
    int          accCnt [2];
    int          takeCnt [2];
    logic        lastAcc0, lastAcc1;

    ext_arbiter #(.RR_INIT(RR)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_sign  (req0_sign),
        .req0_imm   (req0_imm),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_sign  (req1_sign),
        .req1_imm   (req1_imm),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] extRef(input logic [15:0] imm, input logic s);
        if (s && imm >= 16'h8000) return 32'hFFFF0000 + 32'(imm);
        return 32'(imm);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check readies before the edge, then check the result register after it.
    task automatic applyStimulus(input logic v0, input logic s0, input logic [15:0] i0,
                                 input logic v1, input logic s1, input logic [15:0] i1,
                                 input logic rr, input logic rs);
        logic canAcc;
        int   g;
        @(negedge clk);
        rst = rs;
        req0_valid = v0; req0_sign = s0; req0_imm = i0;
        req1_valid = v1; req1_sign = s1; req1_imm = i1;
        rsp_ready = rr;
        #1;
        canAcc = !rs && (!mValid || rr);
        g = -1;
        if (v0 && v1) g = (mLast == 1'b0) ? 1 : 0;
        else if (v0)  g = 0;
        else if (v1)  g = 1;
        checkOutput("req0Ready", 32'(req0_ready), 32'(canAcc && g == 0));
        checkOutput("req1Ready", 32'(req1_ready), 32'(canAcc && g == 1));
        lastAcc0 = canAcc && g == 0;
        lastAcc1 = canAcc && g == 1;
        if (!rs && rsp_valid === 1'b1 && rr) takeCnt[rsp_id ? 1 : 0]++;
        @(posedge clk);
        if (rs) begin
            mValid = 1'b0; mId = 1'b0; mData = 32'h0; mLast = ~RR;
        end else if (canAcc && g >= 0) begin
            mValid = 1'b1;
            mId    = (g == 1);
            mData  = (g == 1) ? extRef(i1, s1) : extRef(i0, s0);
            mLast  = (g == 1);
            accCnt[g]++;
        end else if (rr) begin
            mValid = 1'b0;
        end
        #1;
        checkOutput("rspValid", 32'(rsp_valid), 32'(mValid));
        checkOutput("busy",     32'(busy),      32'(mValid));
        checkOutput("rspId",    32'(rsp_id),    32'(mId));
        checkOutput("rspData",  rsp_data,       mData);
    endtask

    initial begin
        logic        rv0, rs0, rv1, rs1, rr;
        logic [15:0] ri0, ri1;
        logic [15:0] edges [4];
        edges[0] = 16'h8000; edges[1] = 16'h7FFF; edges[2] = 16'hFFFF; edges[3] = 16'h0000;
        mValid = 1'b0; mId = 1'b0; mData = 32'h0; mLast = ~RR;
        accCnt[0] = 0; accCnt[1] = 0; takeCnt[0] = 0; takeCnt[1] = 0;

        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 0, 1);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 0, 1);
        checkOutput("resetValid", 32'(rsp_valid), 32'h0);

        applyStimulus(1, 1, 16'h8001, 0, 0, 16'h0, 1, 0);
        checkOutput("signExt8001", rsp_data, 32'hFFFF8001);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h8001, 1, 0);
        checkOutput("zeroExt8001", rsp_data, 32'h00008001);
        checkOutput("req1Id", 32'(rsp_id), 32'h1);
        applyStimulus(0, 0, 16'h0, 1, 1, 16'h7FFF, 1, 0);
        checkOutput("signExt7FFF", rsp_data, 32'h00007FFF);

        for (int k = 0; k < 6; k++) applyStimulus(1, 1, 16'hA5A5, 1, 0, 16'h1234, 1, 0);

        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 16'h00F0, 1, 1, 16'hF00F, 0, 0);
        applyStimulus(1, 0, 16'h00F0, 1, 1, 16'hF00F, 1, 0);

        applyStimulus(1, 1, 16'h4444, 1, 1, 16'h9999, 0, 0);
        applyStimulus(1, 1, 16'h4444, 1, 1, 16'h9999, 0, 1);
        checkOutput("postResetValid", 32'(rsp_valid), 32'h0);
        applyStimulus(1, 1, 16'h4444, 1, 1, 16'h9999, 1, 0);
        checkOutput("rrInitWinner", 32'(rsp_id), 32'(RR));
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 1, 0);

        accCnt[0] = 0; accCnt[1] = 0; takeCnt[0] = 0; takeCnt[1] = 0;
        if (mValid) accCnt[mId ? 1 : 0] = 1;
        lastAcc0 = 1'b1; lastAcc1 = 1'b1;
        rv0 = 0; rs0 = 0; ri0 = 0; rv1 = 0; rs1 = 0; ri1 = 0;
        for (int n = 0; n < 400; n++) begin
            // A refused requester keeps presenting the same operand.
            if (!rv0 || lastAcc0) begin
                rv0 = ($urandom_range(0, 2) != 0);
                rs0 = 1'($urandom_range(0, 1));
                ri0 = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
            end
            if (!rv1 || lastAcc1) begin
                rv1 = ($urandom_range(0, 2) != 0);
                rs1 = 1'($urandom_range(0, 1));
                ri1 = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
            end
            rr = ($urandom_range(0, 3) != 0);
            applyStimulus(rv0, rs0, ri0, rv1, rs1, ri1, rr, 0);
        end
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 1, 0);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 1, 0);
        checkOutput("delivered0", 32'(takeCnt[0]), 32'(accCnt[0]));
        checkOutput("delivered1", 32'(takeCnt[1]), 32'(accCnt[1]));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
